ras_controller: RTL and testbench

Return-address-stack controller for the fetch-stage branch predictor: sequences speculative push/pop of return addresses from the decoded `is_call`/`is_return` flags and supplies the predicted target for returns. Keeps a second, commit-side copy of the stack updated at instruction retirement. On a pipeline flush it restores the speculative stack from the commit-side copy in one cycle. It sits between the fetch/decode branch classification logic and the next-PC selector.

---
 rtl/ras_controller_pkg.sv | 10 +
 rtl/ras_controller_ras_stack.sv | 74 +++++++
 rtl/ras_controller.sv | 68 ++++++
 tb/tb_ras_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ras_controller_pkg.sv
// Shared constants and types for the return-address-stack controller.
package ras_controller_pkg;

    localparam int RAS_DEPTH = 8;

    typedef logic [31:0]                   uint32_t;
    typedef logic [$clog2(RAS_DEPTH)-1:0]  ras_ptr_t;
    typedef logic [$clog2(RAS_DEPTH):0]    ras_cnt_t;

endpackage

// File: rtl/ras_controller_ras_stack.sv
// One circular return-address stack with a whole-state load port; its
// next-state is exported so another stack can be loaded from it in one cycle.
module ras_stack
    import ras_controller_pkg::*;
#(
    parameter  int DEPTH = RAS_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  uint32_t                addr,
    input  logic                   load,
    input  logic [DEPTH-1:0][31:0] load_entries,
    input  logic [PW-1:0]          load_tp,
    input  logic [CW-1:0]          load_cnt,
    output logic [DEPTH-1:0][31:0] next_entries,
    output logic [PW-1:0]          next_tp,
    output logic [CW-1:0]          next_cnt,
    output uint32_t                top_addr,
    output logic [CW-1:0]          count
);

    logic [DEPTH-1:0][31:0] entries_q, entries_d;
    logic [PW-1:0]          tp_q, tp_d, tp_inc, tp_dec;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign tp_inc = tp_q + PW'(1);
    assign tp_dec = tp_q - PW'(1);

    // Push+pop is an in-place replace of the top; a push into a full stack
    // overwrites the oldest entry and leaves the count saturated.
    always_comb begin
        entries_d = entries_q;
        tp_d      = tp_q;
        cnt_d     = cnt_q;
        if (load) begin
            entries_d = load_entries;
            tp_d      = load_tp;
            cnt_d     = load_cnt;
        end else if (push && pop) begin
            entries_d[tp_q] = addr;
            if (cnt_q == '0) cnt_d = CW'(1);
        end else if (push) begin
            tp_d              = tp_inc;
            entries_d[tp_inc] = addr;
            if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (pop && cnt_q != '0) begin
            tp_d  = tp_dec;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
            tp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            entries_q <= entries_d;
            tp_q      <= tp_d;
            cnt_q     <= cnt_d;
        end
    end

    assign next_entries = entries_d;
    assign next_tp      = tp_d;
    assign next_cnt     = cnt_d;
    assign top_addr     = entries_q[tp_q];
    assign count        = cnt_q;

endmodule

// File: rtl/ras_controller.sv
// Speculative and commit-side return-address stacks; a flush reloads the
// speculative stack from the commit stack's next state in a single cycle.
module ras_controller
    import ras_controller_pkg::*;
#(
    parameter  int DEPTH = RAS_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spec_push,
    input  logic          spec_pop,
    input  uint32_t       spec_push_addr,
    input  logic          commit_push,
    input  logic          commit_pop,
    input  uint32_t       commit_push_addr,
    input  logic          restore,
    output logic          pred_valid,
    output uint32_t       pred_target,
    output logic [CW-1:0] spec_count
);

    logic [DEPTH-1:0][31:0] c_next_entries, s_next_entries;
    logic [PW-1:0]          c_next_tp, s_next_tp;
    logic [CW-1:0]          c_next_cnt, s_next_cnt, c_count;
    uint32_t                c_top;
    logic                   unused_state;

    ras_stack #(.DEPTH(DEPTH)) u_commit (
        .clk          (clk),
        .rst          (rst),
        .push         (commit_push),
        .pop          (commit_pop),
        .addr         (commit_push_addr),
        .load         (1'b0),
        .load_entries ('0),
        .load_tp      ('0),
        .load_cnt     ('0),
        .next_entries (c_next_entries),
        .next_tp      (c_next_tp),
        .next_cnt     (c_next_cnt),
        .top_addr     (c_top),
        .count        (c_count)
    );

    // Speculative ops are dropped in a restore cycle; the load port wins anyway.
    ras_stack #(.DEPTH(DEPTH)) u_spec (
        .clk          (clk),
        .rst          (rst),
        .push         (spec_push & ~restore),
        .pop          (spec_pop & ~restore),
        .addr         (spec_push_addr),
        .load         (restore),
        .load_entries (c_next_entries),
        .load_tp      (c_next_tp),
        .load_cnt     (c_next_cnt),
        .next_entries (s_next_entries),
        .next_tp      (s_next_tp),
        .next_cnt     (s_next_cnt),
        .top_addr     (pred_target),
        .count        (spec_count)
    );

    assign pred_valid   = (spec_count != '0);
    assign unused_state = ^{c_top, c_count, s_next_entries, s_next_tp, s_next_cnt};

endmodule

// File: tb/tb_ras_controller.sv
// Scoreboard bench for ras_controller: directed scenarios plus random traffic
// checked against a circular-buffer reference model of both stacks.
module tb_ras_controller;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          spec_push = 1'b0;
    logic          spec_pop = 1'b0;
    logic [31:0]   spec_push_addr = '0;
    logic          commit_push = 1'b0;
    logic          commit_pop = 1'b0;
    logic [31:0]   commit_push_addr = '0;
    logic          restore = 1'b0;
    logic          pred_valid;
    logic [31:0]   pred_target;
    logic [CW-1:0] spec_count;

    ras_controller #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .spec_push        (spec_push),
        .spec_pop         (spec_pop),
        .spec_push_addr   (spec_push_addr),
        .commit_push      (commit_push),
        .commit_pop       (commit_pop),
        .commit_push_addr (commit_push_addr),
        .restore          (restore),
        .pred_valid       (pred_valid),
        .pred_target      (pred_target),
        .spec_count       (spec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          v;
        logic [31:0]   t;
        logic [CW-1:0] c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: index 0 = speculative, 1 = commit.
    logic [31:0] mEnt[2][DEPTH];
    int          mTp[2];
    int          mCnt[2];

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) mEnt[k][i] = '0;
            mTp[k]  = 0;
            mCnt[k] = 0;
        end
    endfunction

    function automatic void modelOp(int k, bit p, bit q, logic [31:0] a);
        if (p && q) begin
            mEnt[k][mTp[k]] = a;
            if (mCnt[k] == 0) mCnt[k] = 1;
        end else if (p) begin
            mTp[k] = (mTp[k] + 1) % DEPTH;
            mEnt[k][mTp[k]] = a;
            mCnt[k] = (mCnt[k] < DEPTH) ? mCnt[k] + 1 : DEPTH;
        end else if (q && mCnt[k] > 0) begin
            mTp[k]  = (mTp[k] + DEPTH - 1) % DEPTH;
            mCnt[k] = mCnt[k] - 1;
        end
    endfunction

    function automatic void compare(string name, logic ev, logic [31:0] et, logic [CW-1:0] ec);
        total++;
        if (pred_valid !== ev || pred_target !== et || spec_count !== ec) begin
            bad++;
            $display("[TB] FAIL %s: got valid=%0b target=%h count=%0d, expected valid=%0b target=%h count=%0d",
                     name, pred_valid, pred_target, spec_count, ev, et, ec);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e.name, e.v, e.t, e.c);
        end
    end

    // Called just after a rising edge; drives one cycle of inputs.
    task automatic applyStimulus(bit sp, bit spo, logic [31:0] sa,
                                 bit cp, bit cpo, logic [31:0] ca,
                                 bit rs, string name);
        exp_t e;
        spec_push = sp;  spec_pop = spo;  spec_push_addr = sa;
        commit_push = cp; commit_pop = cpo; commit_push_addr = ca;
        restore = rs;
        e.name = name;
        e.v    = (mCnt[0] != 0);
        e.t    = mEnt[0][mTp[0]];
        e.c    = CW'(mCnt[0]);
        sb.push_back(e);
        modelOp(1, cp, cpo, ca);
        if (rs) begin
            mEnt[0] = mEnt[1];
            mTp[0]  = mTp[1];
            mCnt[0] = mCnt[1];
        end else begin
            modelOp(0, sp, spo, sa);
        end
        @(posedge clk);
        #1;
        spec_push = 0; spec_pop = 0; commit_push = 0; commit_pop = 0; restore = 0;
    endtask

    task automatic sPush(logic [31:0] a); applyStimulus(1, 0, a, 0, 0, '0, 0, "spush"); endtask
    task automatic sPop();                applyStimulus(0, 1, '0, 0, 0, '0, 0, "spop");  endtask

    task automatic checkOutput(string name, logic ev, logic [31:0] et, logic [CW-1:0] ec);
        compare(name, ev, et, ec);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, bound 500000 expected");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [31:0] a, b;
        modelReset();
        #1 rst = 1'b1;
        #1 checkOutput("reset", 1'b0, 32'h0, 4'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        sPush(32'h8000_0010);
        sPush(32'h8000_0020);
        checkOutput("push2", 1'b1, 32'h8000_0020, 4'd2);
        sPop();
        checkOutput("pop1", 1'b1, 32'h8000_0010, 4'd1);
        sPop();
        sPop();
        checkOutput("underflow", 1'b0, 32'h0, 4'd0);
        sPush(32'hBFC0_0008);
        checkOutput("push_after_empty", 1'b1, 32'hBFC0_0008, 4'd1);
        sPop();

        for (int i = 1; i <= 9; i++) sPush(32'(i * 32'h100));
        checkOutput("wrap_full", 1'b1, 32'h900, 4'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("wrap_pop", 1'b1, 32'(32'h900 - i * 32'h100), CW'(8 - i));
            sPop();
        end
        sPop();
        checkOutput("wrap_drained", 1'b0, pred_target, 4'd0);

        sPush(32'h100); sPush(32'h200); sPush(32'h300);
        applyStimulus(1, 1, 32'h444, 0, 0, '0, 0, "pushpop");
        checkOutput("pushpop", 1'b1, 32'h444, 4'd3);
        sPop();
        checkOutput("pushpop_below", 1'b1, 32'h200, 4'd2);
        sPop(); sPop();

        applyStimulus(0, 0, '0, 1, 0, 32'hA0, 0, "cpush");
        sPush(32'hB0);
        sPush(32'hC0);
        applyStimulus(0, 0, '0, 1, 0, 32'hD0, 1, "restore");
        checkOutput("restore", 1'b1, 32'hD0, 4'd2);
        sPop();
        checkOutput("restore_pop", 1'b1, 32'hA0, 4'd1);

        for (int i = 0; i < 4; i++) sPush(32'(32'h5000 + i * 4));
        checkOutput("pre_async", 1'b1, 32'h500C, 4'd5);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst", 1'b0, 32'h0, 4'd0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;
        sPush(32'h1234);
        checkOutput("post_rst", 1'b1, 32'h1234, 4'd1);

        for (int i = 0; i < 1500; i++) begin
            a = $urandom() & 32'hFFFF_FFFC;
            b = $urandom() & 32'hFFFF_FFFC;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b,
                          ($urandom_range(0, 15) == 0), "random");
        end
        applyStimulus(0, 0, '0, 0, 0, '0, 0, "final");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
